// File: rtl/store_pkg.sv
// Shared definitions for the store path: access-size encodings, the serializer
// state encoding, and the alignment check used when a request is accepted.
package store_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StBeat0 = 3'd1,
        StBeat1 = 3'd2,
        StResp  = 3'd3,
        StErr   = 3'd4
    } state_t;

    // Size 2'b11 is not a legal access and is reported the same way as a misaligned one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_mux.sv
// Combinational lane steering for a 16-bit data-memory port.
// Ports:
//   size  - access size (byte/half/word)
//   addr0 - byte address bit 0 (selects the lane of a byte store)
//   beat  - 0 for the first beat, 1 for the second beat of a word store
//   data  - 32-bit register data
//   wdata - 16-bit lane data for this beat
//   be    - byte enables, bit1 = [15:8], bit0 = [7:0]
module store_lane_mux
    import store_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [1:0]  size,
    input  logic        addr0,
    input  logic        beat,
    input  logic [31:0] data,
    output logic [15:0] wdata,
    output logic [1:0]  be
);

    logic hi_lane;
    logic hi_half_first;

    // Even byte addresses land in the low lane for little-endian, high lane for big-endian.
    assign hi_lane       = addr0 ^ BIG_ENDIAN;
    // Which half of a word goes out on this beat.
    assign hi_half_first = beat ^ BIG_ENDIAN;

    always_comb begin
        wdata = 16'h0000;
        be    = 2'b00;
        case (size)
            SIZE_BYTE: begin
                wdata = {data[7:0], data[7:0]};
                be    = hi_lane ? 2'b10 : 2'b01;
            end
            SIZE_HALF: begin
                wdata = data[15:0];
                be    = 2'b11;
            end
            SIZE_WORD: begin
                wdata = hi_half_first ? data[31:16] : data[15:0];
                be    = 2'b11;
            end
            default: begin
                wdata = 16'h0000;
                be    = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/store_halfword_serializer.sv
// Narrows 32-bit CPU stores (sb/sh/sw) onto a 16-bit data-memory write port.
// Word stores go out as two halfword beats; byte/half stores are a single beat
// with lane strobes. Misaligned or illegal requests get an error response and
// write nothing.
// Ports:
//   clk, rst_n                   - clock, synchronous active-low reset
//   req_valid/req_ready          - request handshake from the MEM stage
//   req_addr/req_data/req_size   - byte address, register data, access size
//   mem_valid/mem_ready          - write beat handshake to data RAM
//   mem_addr/mem_wdata/mem_be    - halfword address, write data, byte enables
//   resp_valid/resp_err          - one-cycle completion pulse and error flag
module store_halfword_serializer
    import store_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_be,
    output logic              resp_valid,
    output logic              resp_err
);

    localparam logic [ADDR_W-2:0] HalfwordStep = {{(ADDR_W-2){1'b0}}, 1'b1};

    state_t      state;
    logic [31:0] data_q;
    logic [1:0]  size_q;
    logic        addr0_q;

    logic [1:0]  mux_size;
    logic        mux_addr0;
    logic        mux_beat;
    logic [31:0] mux_data;
    logic [15:0] mux_wdata;
    logic [1:0]  mux_be;

    // The mux always computes the payload of the *next* beat: in idle it looks at the
    // incoming request (first beat), otherwise at the latched request (second beat).
    always_comb begin
        if (state == StIdle) begin
            mux_size  = req_size;
            mux_addr0 = req_addr[0];
            mux_beat  = 1'b0;
            mux_data  = req_data;
        end else begin
            mux_size  = size_q;
            mux_addr0 = addr0_q;
            mux_beat  = 1'b1;
            mux_data  = data_q;
        end
    end

    store_lane_mux #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_mux (
        .size  (mux_size),
        .addr0 (mux_addr0),
        .beat  (mux_beat),
        .data  (mux_data),
        .wdata (mux_wdata),
        .be    (mux_be)
    );

    // Payload registers are only written on entry to a beat state, so they stay
    // stable for as long as a beat is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StIdle;
            req_ready  <= 1'b0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 16'h0000;
            mem_be     <= 2'b00;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            data_q     <= 32'h0;
            size_q     <= 2'b00;
            addr0_q    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        data_q    <= req_data;
                        size_q    <= req_size;
                        addr0_q   <= req_addr[0];
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            state      <= StErr;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state     <= StBeat0;
                            mem_valid <= 1'b1;
                            mem_addr  <= req_addr[ADDR_W-1:1];
                            mem_wdata <= mux_wdata;
                            mem_be    <= mux_be;
                        end
                    end
                end
                StBeat0: begin
                    if (mem_ready) begin
                        if (size_q == SIZE_WORD) begin
                            state     <= StBeat1;
                            mem_addr  <= mem_addr + HalfwordStep;
                            mem_wdata <= mux_wdata;
                            mem_be    <= mux_be;
                        end else begin
                            state      <= StResp;
                            mem_valid  <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                        end
                    end
                end
                StBeat1: begin
                    if (mem_ready) begin
                        state      <= StResp;
                        mem_valid  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                    end
                end
                StResp, StErr: begin
                    state      <= StIdle;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                end
                default: begin
                    state      <= StIdle;
                    req_ready  <= 1'b0;
                    mem_valid  <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_halfword_serializer.sv
module tb_store_halfword_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_ready;

    logic        l_req_ready, b_req_ready;
    logic        l_mem_valid, b_mem_valid;
    logic [30:0] l_mem_addr, b_mem_addr;
    logic [15:0] l_mem_wdata, b_mem_wdata;
    logic [1:0]  l_mem_be, b_mem_be;
    logic        l_resp_valid, b_resp_valid;
    logic        l_resp_err, b_resp_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    store_halfword_serializer #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (l_req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_size   (req_size),
        .mem_valid  (l_mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (l_mem_addr),
        .mem_wdata  (l_mem_wdata),
        .mem_be     (l_mem_be),
        .resp_valid (l_resp_valid),
        .resp_err   (l_resp_err)
    );

    store_halfword_serializer #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut_be (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (b_req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_size   (req_size),
        .mem_valid  (b_mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (b_mem_addr),
        .mem_wdata  (b_mem_wdata),
        .mem_be     (b_mem_be),
        .resp_valid (b_resp_valid),
        .resp_err   (b_resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: lay the store out as a little run of bytes in memory order,
    // then cut that run into halfword beats and place each byte in its lane.
    task automatic model(input bit big, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, output bit err, output int n,
                         output logic [1:0][30:0] ha, output logic [1:0][15:0] wd,
                         output logic [1:0][1:0] be);
        int unsigned nb;
        logic [7:0] m [4];
        logic [63:0] hw;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3) || ((a % nb) != 0);
        n   = (nb == 4) ? 2 : 1;
        ha  = '0;
        wd  = '0;
        be  = '0;
        for (int k = 0; k < 4; k++) m[k] = 8'h00;
        for (int k = 0; k < int'(nb); k++)
            m[k] = 8'((big ? (d >> (8 * (nb - 1 - k))) : (d >> (8 * k))) & 32'hFF);
        for (int b = 0; b < n; b++) begin
            hw = ((64'(a) >> 1) + 64'(b)) % 64'h8000_0000;
            ha[b] = hw[30:0];
            if (nb == 1) begin
                wd[b] = {m[0], m[0]};
                be[b] = (a[0] ^ big) ? 2'b10 : 2'b01;
            end else begin
                // m[2b] sits at the even address of this halfword.
                wd[b] = big ? {m[2*b], m[2*b+1]} : {m[2*b+1], m[2*b]};
                be[b] = 2'b11;
            end
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                            input int stall);
        bit                 l_err, b_err;
        int                 l_n, b_n;
        logic [1:0][30:0]   l_ha, b_ha;
        logic [1:0][15:0]   l_wd, b_wd;
        logic [1:0][1:0]    l_be, b_be;
        int                 w;
        model(1'b0, a, d, sz, l_err, l_n, l_ha, l_wd, l_be);
        model(1'b1, a, d, sz, b_err, b_n, b_ha, b_wd, b_be);
        w = 0;
        while (!(l_req_ready && b_req_ready) && w < 20) begin
            step();
            w++;
        end
        chk("req_ready_wait", {62'd0, l_req_ready, b_req_ready}, 64'd3);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        mem_ready = 1'b1;
        step();
        // Scramble the request bus so the DUT must rely on its latched copy.
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        if (l_err) begin
            chk("err_mem_valid", {62'd0, l_mem_valid, b_mem_valid}, 64'd0);
            chk("err_resp_valid", {62'd0, l_resp_valid, b_resp_valid}, 64'd3);
            chk("err_resp_err", {62'd0, l_resp_err, b_resp_err}, 64'd3);
            chk("err_req_ready", {62'd0, l_req_ready, b_req_ready}, 64'd0);
            step();
        end else begin
            for (int b = 0; b < l_n; b++) begin
                for (int s = 0; s <= stall; s++) begin
                    mem_ready = (s == stall);
                    chk("beat_valid", {62'd0, l_mem_valid, b_mem_valid}, 64'd3);
                    chk("beat_le", {l_mem_addr, l_mem_wdata, l_mem_be},
                        {l_ha[b], l_wd[b], l_be[b]});
                    chk("beat_be", {b_mem_addr, b_mem_wdata, b_mem_be},
                        {b_ha[b], b_wd[b], b_be[b]});
                    chk("beat_busy", {60'd0, l_req_ready, b_req_ready, l_resp_valid,
                        b_resp_valid}, 64'd0);
                    step();
                end
            end
            mem_ready = 1'b1;
            chk("resp_mem_valid", {62'd0, l_mem_valid, b_mem_valid}, 64'd0);
            chk("resp_valid", {62'd0, l_resp_valid, b_resp_valid}, 64'd3);
            chk("resp_err", {62'd0, l_resp_err, b_resp_err}, 64'd0);
            chk("resp_req_ready", {62'd0, l_req_ready, b_req_ready}, 64'd0);
            step();
        end
        chk("after_resp", {62'd0, l_resp_valid, b_resp_valid}, 64'd0);
        chk("ready_again", {62'd0, l_req_ready, b_req_ready}, 64'd3);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_data  = 32'h0;
        req_size  = 2'b00;
        mem_ready = 1'b1;
        step();
        step();
        chk("reset_ctrl", {56'd0, l_req_ready, b_req_ready, l_mem_valid, b_mem_valid,
            l_resp_valid, b_resp_valid, l_resp_err, b_resp_err}, 64'd0);
        chk("reset_pay_le", {l_mem_addr, l_mem_wdata, l_mem_be}, 64'd0);
        chk("reset_pay_be", {b_mem_addr, b_mem_wdata, b_mem_be}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", {62'd0, l_req_ready, b_req_ready}, 64'd3);

        do_store(32'h0000_1001, 32'h0000_00A5, 2'b00, 0);
        do_store(32'h0000_2000, 32'hDEAD_BEEF, 2'b10, 0);
        do_store(32'h0000_0003, 32'h1234_5678, 2'b01, 0);
        do_store(32'h0000_0000, 32'h1234_5678, 2'b11, 0);
        do_store(32'h0000_0102, 32'h0000_CAFE, 2'b01, 1);
        do_store(32'h0000_4000, 32'h0123_4567, 2'b10, 3);
        do_store(32'hFFFF_FFFC, 32'h89AB_CDEF, 2'b10, 0);
        do_store(32'hFFFF_FFFF, 32'h0000_005A, 2'b00, 2);

        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            do_store(a, $urandom, sz, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a stalled second beat.
        req_valid = 1'b1;
        req_addr  = 32'h0000_0040;
        req_data  = 32'h5555_AAAA;
        req_size  = 2'b10;
        mem_ready = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        mem_ready = 1'b0;
        step();
        chk("stall_beat1_valid", {62'd0, l_mem_valid, b_mem_valid}, 64'd3);
        rst_n = 1'b0;
        step();
        chk("midreset_ctrl", {56'd0, l_req_ready, b_req_ready, l_mem_valid, b_mem_valid,
            l_resp_valid, b_resp_valid, l_resp_err, b_resp_err}, 64'd0);
        chk("midreset_pay_le", {l_mem_addr, l_mem_wdata, l_mem_be}, 64'd0);
        chk("midreset_pay_be", {b_mem_addr, b_mem_wdata, b_mem_be}, 64'd0);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("no_resp_after_reset", {60'd0, l_resp_valid, b_resp_valid, l_mem_valid,
                b_mem_valid}, 64'd0);
            step();
        end
        do_store(32'h0000_1001, 32'h0000_00A5, 2'b00, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
